decoder_n_m_scan: RTL and testbench
===================================

# decoder_n_m_scan

Parametrised, registered N-to-M one-hot decoder with enable, selectable output polarity and an autonomous scan mode. Direct mode decodes an external select. Scan mode walks the active output through 0..M-1 at a programmable rate, e.g. for digit/row strobing of multiplexed displays on the education boards. It generalises the combinational 2-to-4 active-low decoder into a clocked, reusable block.

## Interface

- `N`, 2: select/index width, 1..8.
- `M`, 2**N: number of outputs, 2..2**N.
- `ACTIVE_LOW`, 1: 1 means the active output is 0 and inactive outputs are 1; 0 means the inverse.
- `SCAN_DIV`, 4: clock cycles each index is held in scan mode, ≥1.

Ports:

- `clk` input 1: single clock; all logic is rising-edge.
- `reset` input 1: synchronous, active-high.
- `en` input 1: block enable.
- `mode` input 1: 0 selects direct decode, 1 selects scan.
- `sel` input N: select value, direct mode only.
- `y` output M: decoded outputs, registered.
- `idx` output N: index currently driven active on `y`, registered.
- `err` output 1: direct mode only; high when the registered `sel` is ≥ M.
- `wrap` output 1: one-cycle pulse, scan mode only, on return from index M-1 to 0.

## Operation

- **Reset values:** `y` is all inactive (all ones if `ACTIVE_LOW`=1, else all zeros). `idx`=0, `err`=0, `wrap`=0. State is IDLE and the prescaler is 0.
- **Inactive level:** bit k inactive equals `ACTIVE_LOW`. Active is its complement.
- **State is a function of inputs:**
  - `en`=0 gives IDLE.
  - `en`=1 and `mode`=0 gives DIRECT.
  - `en`=1 and `mode`=1 gives SCAN.
  - Transitions are evaluated every cycle.
- **IDLE:**
  - `y` is all inactive.
  - `idx` holds its last value.
  - `err`=0, `wrap`=0.
  - The prescaler is held.
- **DIRECT:**
  - `idx` takes `sel`.
  - If `sel`<M, bit `sel` of `y` is active and all other bits are inactive; `err`=0.
  - If `sel`≥M, `y` is all inactive and `err`=1.
  - `wrap`=0.
- **SCAN entry:** on any transition into SCAN from IDLE or DIRECT, `idx` is forced to 0 and the prescaler is cleared. `wrap` is not asserted on entry.
- **SCAN steady state:**
  - The prescaler counts 0..SCAN_DIV-1.
  - When it is SCAN_DIV-1, it returns to 0 and `idx` advances: `idx`+1, or 0 if `idx`=M-1.
  - `y` always shows `idx` active.
  - `err`=0.
- **Scan wrap:** `wrap`=1 in exactly the cycle the registered `idx` changes from M-1 to 0.
- **SCAN_DIV=1:** `idx` advances every cycle.
- **M<2**N:** scan never visits codes ≥ M.
- **Width rules:** the prescaler is sized to clog2(SCAN_DIV), minimum 1 bit. The `idx` comparison against M-1 is exact, with no reliance on natural N-bit wrap.
- **Simultaneous events:** `reset` overrides everything. When mode changes in the same cycle as a prescaler terminal count, the mode change wins: re-entry to SCAN yields `idx`=0 and no `wrap`.
- **Reset mid-scan:** next cycle all outputs take reset values. Scan restarts from 0 once `en`/`mode` select SCAN.

## Timing

- **Latency:** one cycle from inputs (`en`, `mode`, `sel`) to `y`/`idx`/`err`. No combinational path from input to output.
- **Dwell time:** in SCAN, each index is held on `y` for exactly SCAN_DIV cycles; the first index 0 after entry is also SCAN_DIV cycles.
- **Scan period:** M*SCAN_DIV cycles. `wrap` pulses once per period, starting with the first return to 0.
- **Outputs:** `y` and `idx` are always mutually consistent, since both are registered in the same cycle.

## Test plan

All scenarios use N=2, M=4, ACTIVE_LOW=1, SCAN_DIV=3 unless noted.

1. **Reset:**
   - Stimulus: assert `reset` with `en`=1, `mode`=0, `sel`=2.
   - Response: next edge `y`=4'b1111, `idx`=0, `err`=0, `wrap`=0.
   - Stimulus: release `reset`.
   - Response: one cycle later `y`=4'b1011.
2. **Direct sweep:**
   - Stimulus: `sel`=0,1,2,3 on consecutive cycles.
   - Response: `y`=1110, 1101, 1011, 0111, each one cycle after its `sel`.
   - Stimulus: `en`=0.
   - Response: `y`=1111 and `idx` holds 3.
3. **Out of range:**
   - Stimulus: M=3, `sel`=3.
   - Response: `y`=3'b111, `err`=1.
   - Stimulus: `sel`=1.
   - Response: `y`=3'b101, `err`=0.
4. **Scan:**
   - Stimulus: `en`=1, `mode`=1 from IDLE.
   - Response: `idx` sequence 0,0,0,1,1,1,2,2,2,3,3,3,0.
   - Response: `wrap`=1 only at the final 0, i.e. 12 cycles after entry.
5. **Mode collision:**
   - Stimulus: in SCAN at `idx`=2, drop `mode` to 0 for one cycle with `sel`=1, then back to 1.
   - Response: `y`=1101.
   - Response: then `idx`=0 for 3 cycles, `wrap`=0.
6. **ACTIVE_LOW=0, SCAN_DIV=1:**
   - Response: `y`=0001, 0010, 0100, 1000, 0001 on consecutive cycles.
   - Response: `wrap` is high with the second 0001.
   - Stimulus: `reset` mid-sequence.
   - Response: `y`=0000 next cycle.

Source files
------------

// File: rtl/decoder_n_m_scan.sv
// Registered N-to-M one-hot decoder with enable, selectable output polarity and
// an autonomous scan mode that walks the active output through 0..M-1.
module decoder_n_m_scan #(
    parameter int N          = 2,
    parameter int M          = 2 ** N,
    parameter int ACTIVE_LOW = 1,
    parameter int SCAN_DIV   = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         mode,
    input  logic [N-1:0] sel,
    output logic [M-1:0] y,
    output logic [N-1:0] idx,
    output logic         err,
    output logic         wrap,
    output logic [1:0]   dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DIRECT = 2'd1,
        S_SCAN   = 2'd2
    } state_e;

    localparam int            PW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] DIV_LAST = PW'(SCAN_DIV - 1);
    localparam logic [N-1:0]  IDX_LAST = N'(M - 1);
    localparam logic [N:0]    M_EXT    = (N + 1)'(M);
    localparam logic          INACT    = (ACTIVE_LOW != 0);

    state_e        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [N-1:0]  idx_q, idx_d;
    logic [M-1:0]  y_q, y_d;
    logic          err_q, err_d;
    logic          wrap_q, wrap_d;
    logic          show;

    always_comb begin
        state_d = S_IDLE;
        if (en) begin
            state_d = mode ? S_SCAN : S_DIRECT;
        end
        idx_d   = idx_q;
        presc_d = presc_q;
        err_d   = 1'b0;
        wrap_d  = 1'b0;
        show    = 1'b0;

        case (state_d)
            S_DIRECT: begin
                idx_d = sel;
                if ({1'b0, sel} < M_EXT) begin
                    show = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
            end
            S_SCAN: begin
                show = 1'b1;
                // Entry (or re-entry after a mode glitch) always restarts at 0 with no wrap.
                if (state_q != S_SCAN) begin
                    idx_d   = '0;
                    presc_d = '0;
                end else if (presc_q == DIV_LAST) begin
                    presc_d = '0;
                    if (idx_q == IDX_LAST) begin
                        idx_d  = '0;
                        wrap_d = 1'b1;
                    end else begin
                        idx_d = idx_q + N'(1);
                    end
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end
            default: ;
        endcase

        for (int k = 0; k < M; k++) begin
            y_d[k] = (show && (idx_d == N'(k))) ? ~INACT : INACT;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            presc_q <= '0;
            idx_q   <= '0;
            y_q     <= {M{INACT}};
            err_q   <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            idx_q   <= idx_d;
            y_q     <= y_d;
            err_q   <= err_d;
            wrap_q  <= wrap_d;
        end
    end

    assign y         = y_q;
    assign idx       = idx_q;
    assign err       = err_q;
    assign wrap      = wrap_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_decoder_n_m_scan.sv
// Bench for decoder_n_m_scan: three configurations share one stimulus stream and
// are compared each cycle against a cycle-count based model, plus fixed vectors.
module tb_decoder_n_m_scan;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, en, mode;
    logic [1:0] sel;

    logic [3:0] y_a, y_c;
    logic [2:0] y_b;
    logic [1:0] idx_a, idx_b, idx_c;
    logic       err_a, err_b, err_c;
    logic       wrap_a, wrap_b, wrap_c;
    logic [1:0] dbg_a, dbg_b, dbg_c;

    int checks = 0;
    int errors = 0;

    // a: M=4, active-low, div 3   b: M=3, active-low, div 3   c: M=4, active-high, div 1
    decoder_n_m_scan #(.N(2), .M(4), .ACTIVE_LOW(1), .SCAN_DIV(3)) dut_a (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .sel(sel),
        .y(y_a), .idx(idx_a), .err(err_a), .wrap(wrap_a), .dbg_state(dbg_a));
    decoder_n_m_scan #(.N(2), .M(3), .ACTIVE_LOW(1), .SCAN_DIV(3)) dut_b (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .sel(sel),
        .y(y_b), .idx(idx_b), .err(err_b), .wrap(wrap_b), .dbg_state(dbg_b));
    decoder_n_m_scan #(.N(2), .M(4), .ACTIVE_LOW(0), .SCAN_DIV(1)) dut_c (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .sel(sel),
        .y(y_c), .idx(idx_c), .err(err_c), .wrap(wrap_c), .dbg_state(dbg_c));

    // Reference model: scan position is the number of cycles spent in scan since entry.
    int         m_prev[3];
    int         m_t[3];
    int         m_idx[3];
    logic [3:0] m_y[3];
    logic       m_err[3];
    logic       m_wrap[3];

    function automatic int cfg_m(int c);
        return (c == 1) ? 3 : 4;
    endfunction

    function automatic bit cfg_al(int c);
        return (c != 2);
    endfunction

    function automatic int cfg_div(int c);
        return (c == 2) ? 1 : 3;
    endfunction

    function automatic logic [3:0] dec(int c, bit active, int k);
        logic [3:0] r;
        r = '0;
        for (int b = 0; b < cfg_m(c); b++) begin
            r[b] = (active && (b == k)) ? !cfg_al(c) : cfg_al(c);
        end
        return r;
    endfunction

    task automatic model_update();
        int ns;
        for (int c = 0; c < 3; c++) begin
            if (reset) begin
                m_prev[c] = 0;
                m_t[c]    = 0;
                m_idx[c]  = 0;
                m_y[c]    = dec(c, 1'b0, 0);
                m_err[c]  = 1'b0;
                m_wrap[c] = 1'b0;
            end else begin
                ns        = !en ? 0 : (mode ? 2 : 1);
                m_err[c]  = 1'b0;
                m_wrap[c] = 1'b0;
                if (ns == 0) begin
                    m_y[c] = dec(c, 1'b0, 0);
                end else if (ns == 1) begin
                    m_idx[c] = int'(sel);
                    if (int'(sel) < cfg_m(c)) begin
                        m_y[c] = dec(c, 1'b1, int'(sel));
                    end else begin
                        m_y[c]   = dec(c, 1'b0, 0);
                        m_err[c] = 1'b1;
                    end
                end else begin
                    m_t[c]    = (m_prev[c] == 2) ? m_t[c] + 1 : 0;
                    m_idx[c]  = (m_t[c] / cfg_div(c)) % cfg_m(c);
                    m_wrap[c] = (m_t[c] > 0) && (m_t[c] % (cfg_m(c) * cfg_div(c)) == 0);
                    m_y[c]    = dec(c, 1'b1, m_idx[c]);
                end
                m_prev[c] = ns;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic check_model();
        chk("a_y", 32'(y_a), 32'(m_y[0]));
        chk("a_idx", 32'(idx_a), 32'(m_idx[0]));
        chk("a_err", 32'(err_a), 32'(m_err[0]));
        chk("a_wrap", 32'(wrap_a), 32'(m_wrap[0]));
        chk("b_y", 32'({1'b0, y_b}), 32'(m_y[1]));
        chk("b_idx", 32'(idx_b), 32'(m_idx[1]));
        chk("b_err", 32'(err_b), 32'(m_err[1]));
        chk("b_wrap", 32'(wrap_b), 32'(m_wrap[1]));
        chk("c_y", 32'(y_c), 32'(m_y[2]));
        chk("c_idx", 32'(idx_c), 32'(m_idx[2]));
        chk("c_err", 32'(err_c), 32'(m_err[2]));
        chk("c_wrap", 32'(wrap_c), 32'(m_wrap[2]));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_update();
        check_model();
    endtask

    typedef struct {
        logic       rst;
        logic       en;
        logic       mode;
        logic [1:0] sel;
        logic [3:0] y_a;
        logic [1:0] idx_a;
        logic [2:0] y_b;
        logic       err_b;
    } vec_t;

    vec_t       vecs[8];
    int         exp_idx[13];
    logic [3:0] exp_yc[5];

    initial begin
        reset = 1'b1;
        en    = 1'b1;
        mode  = 1'b0;
        sel   = 2'd2;

        vecs[0] = '{1'b1, 1'b1, 1'b0, 2'd2, 4'b1111, 2'd0, 3'b111, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 2'd2, 4'b1011, 2'd2, 3'b011, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 2'd0, 4'b1110, 2'd0, 3'b110, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 2'd1, 4'b1101, 2'd1, 3'b101, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 2'd2, 4'b1011, 2'd2, 3'b011, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 2'd3, 4'b0111, 2'd3, 3'b111, 1'b1};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 2'd0, 4'b1111, 2'd3, 3'b111, 1'b0};
        vecs[7] = '{1'b0, 1'b1, 1'b0, 2'd1, 4'b1101, 2'd1, 3'b101, 1'b0};
        exp_idx = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};
        exp_yc  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        // Reset, direct sweep, idle hold and out-of-range decode.
        for (int i = 0; i < 8; i++) begin
            reset = vecs[i].rst;
            en    = vecs[i].en;
            mode  = vecs[i].mode;
            sel   = vecs[i].sel;
            step();
            chk("tbl_y_a", 32'(y_a), 32'(vecs[i].y_a));
            chk("tbl_idx_a", 32'(idx_a), 32'(vecs[i].idx_a));
            chk("tbl_y_b", 32'(y_b), 32'(vecs[i].y_b));
            chk("tbl_err_b", 32'(err_b), 32'(vecs[i].err_b));
        end

        // Scan entry from IDLE: full period on a, single-cycle dwell on c.
        en = 1'b0;
        step();
        en   = 1'b1;
        mode = 1'b1;
        for (int i = 0; i < 13; i++) begin
            step();
            chk("scan_idx_a", 32'(idx_a), 32'(exp_idx[i]));
            chk("scan_wrap_a", 32'(wrap_a), 32'(i == 12));
            if (i < 5) begin
                chk("scan_y_c", 32'(y_c), 32'(exp_yc[i]));
                chk("scan_wrap_c", 32'(wrap_c), 32'(i == 4));
            end
        end

        // Advance to index 2, then a one-cycle drop to direct mode.
        repeat (6) step();
        chk("pre_coll_idx_a", 32'(idx_a), 32'd2);
        mode = 1'b0;
        sel  = 2'd1;
        step();
        chk("coll_y_a", 32'(y_a), 32'(4'b1101));
        mode = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("coll_idx_a", 32'(idx_a), 32'd0);
            chk("coll_wrap_a", 32'(wrap_a), 32'd0);
        end

        // Reset in the middle of a scan.
        reset = 1'b1;
        step();
        chk("rst_y_c", 32'(y_c), 32'(4'b0000));
        chk("rst_y_a", 32'(y_a), 32'(4'b1111));
        chk("rst_idx_a", 32'(idx_a), 32'd0);
        reset = 1'b0;

        // Random traffic; mode flips rarely so full scan periods occur.
        repeat (500) begin
            reset = ($urandom_range(0, 40) == 0);
            en    = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            sel   = 2'($urandom_range(0, 3));
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
